// File: rtl/wave_pkg.sv
// wave_pkg: shared state encoding, frame geometry and display conversion for the waveform capture path
package wave_pkg;
    typedef enum logic [1:0] {ARMED = 2'd0, ACTIVE = 2'd1, WAIT = 2'd2} state_t;
    localparam int SAMPLES_PER_FRAME = 256;
    localparam int ADDR_W = 9;
    localparam int DISP_W = 8;
    // Offset-binary top byte of a signed sample: 128 represents zero.
    function automatic logic [DISP_W-1:0] to_display(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction
endpackage

// File: rtl/wave_capture_sched_sample_decimator.sv
// sample_decimator: keeps one of every DECIMATE strobed samples and remembers the sign of the last kept one
//   clk, reset        : clock, synchronous active-high reset
//   new_sample_ready  : input strobe qualifying sample_msb
//   sample_msb        : sign bit of the incoming sample
//   kept              : combinational, high when the current strobe is a kept sample
//   prev_neg          : registered sign of the most recent kept sample
module sample_decimator #(
    parameter int DECIMATE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic new_sample_ready,
    input  logic sample_msb,
    output logic kept,
    output logic prev_neg
);
    logic [7:0] cnt_q, cnt_d;
    logic       prev_neg_q, prev_neg_d;
    always_comb begin
        kept       = new_sample_ready && cnt_q == 8'(DECIMATE - 1);
        cnt_d      = kept ? 8'd0 : new_sample_ready ? cnt_q + 8'd1 : cnt_q;
        prev_neg_d = kept ? sample_msb : prev_neg_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            prev_neg_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prev_neg_q <= prev_neg_d;
        end
    end
    assign prev_neg = prev_neg_q;
endmodule

// File: rtl/wave_capture_sched.sv
// wave_capture_sched: triggers on a positive zero crossing (or timeout), captures 256 decimated samples
// into the hidden half of the ping-pong display RAM, then flips read_index during display blanking.
//   clk, reset        : clock, synchronous active-high reset
//   new_sample_ready  : one-cycle strobe qualifying new_sample_in (signed 16-bit)
//   wave_display_idle : display is in blanking, safe to swap halves
//   write_enable/write_address/write_sample : registered RAM write port
//   read_index        : half shown by the display; armed : FSM is waiting for a trigger
module wave_capture_sched
    import wave_pkg::*;
#(
    parameter int DECIMATE     = 1,
    parameter int TRIG_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_sample_ready,
    input  logic [15:0]       new_sample_in,
    input  logic              wave_display_idle,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DISP_W-1:0] write_sample,
    output logic              read_index,
    output logic              armed
);
    state_t            state_q, state_d;
    logic              read_index_q, read_index_d;
    logic              write_enable_q, write_enable_d;
    logic [ADDR_W-1:0] write_address_q, write_address_d;
    logic [DISP_W-1:0] write_sample_q, write_sample_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              kept, prev_neg, trig, wr, flip;
    // The low byte is dropped by the 8-bit display conversion.
    logic              unused_lsbs;
    assign unused_lsbs = ^new_sample_in[7:0];
    sample_decimator #(.DECIMATE(DECIMATE)) u_dec (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .sample_msb       (new_sample_in[15]),
        .kept             (kept),
        .prev_neg         (prev_neg)
    );
    always_comb begin
        trig = kept && state_q == ARMED &&
               ((prev_neg && !new_sample_in[15]) ||
                (TRIG_TIMEOUT != 0 && tmo_q == 32'(TRIG_TIMEOUT - 1)));
        wr   = trig || (kept && state_q == ACTIVE);
        flip = state_q == WAIT && wave_display_idle;
        state_d = trig ? ACTIVE
                : (state_q == ACTIVE && kept && cnt_q == 8'(SAMPLES_PER_FRAME - 1)) ? WAIT
                : flip ? ARMED : state_q;
        read_index_d    = read_index_q ^ flip;
        cnt_d           = trig ? 8'd1 : wr ? cnt_q + 8'd1 : cnt_q;
        tmo_d           = (state_q != ARMED || trig) ? 32'd0 : kept ? tmo_q + 32'd1 : tmo_q;
        write_enable_d  = wr;
        // Capture always lands in the half the display is not reading.
        write_address_d = wr ? {~read_index_q, trig ? 8'd0 : cnt_q} : write_address_q;
        write_sample_d  = wr ? to_display(new_sample_in) : write_sample_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ARMED;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
            cnt_q           <= '0;
            tmo_q           <= '0;
        end else begin
            state_q         <= state_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
            cnt_q           <= cnt_d;
            tmo_q           <= tmo_d;
        end
    end
    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;
    assign armed         = state_q == ARMED;
endmodule
